// File: rtl/lbp_pkg.sv
// -----------------------------------------------------------------------------
// lbp_pkg : image geometry, LBP code width and histogram FSM states
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package lbp_pkg;

  localparam int IMG_W    = 128;
  localparam int IMG_H    = 128;
  localparam int LBP_W    = 8;
  localparam int NUM_BINS = 256;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 7;
  localparam int ADDR_W   = COL_W + ROW_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // The LBP stage only produces codes for interior pixels, so a border
  // address indicates an upstream addressing fault.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    col = addr[COL_W-1:0];
    row = addr[ADDR_W-1:COL_W];
    return (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lbp_hist_bank.sv
// -----------------------------------------------------------------------------
// lbp_hist_bank : 256-entry counter bank with clear, saturating increment and
//                 registered read port (read bypasses same-cycle writes)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_en_i,
  input  logic [LBP_W-1:0] clr_idx_i,
  input  logic             inc_en_i,
  input  logic [LBP_W-1:0] inc_idx_i,
  input  logic             rd_en_i,
  input  logic [LBP_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_data_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bin_q [NUM_BINS];
  logic [CNT_W-1:0] inc_val;
  logic [CNT_W-1:0] rd_d;
  logic [CNT_W-1:0] rd_q;

  assign inc_val = (bin_q[inc_idx_i] == CNT_MAX) ? CNT_MAX
                                                 : bin_q[inc_idx_i] + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      bin_q[clr_idx_i] <= '0;
    end else if (inc_en_i) begin
      bin_q[inc_idx_i] <= inc_val;
    end
  end

  // Forward a write landing this cycle so the read reflects the final count.
  always_comb begin
    rd_d = '0;
    if (rd_en_i) begin
      if (clr_en_i && (clr_idx_i == rd_idx_i)) begin
        rd_d = '0;
      end else if (inc_en_i && (inc_idx_i == rd_idx_i)) begin
        rd_d = inc_val;
      end else begin
        rd_d = bin_q[rd_idx_i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data_o = rd_q;

endmodule

`default_nettype wire

// File: rtl/lbp_hist.sv
// -----------------------------------------------------------------------------
// lbp_hist : LBP code histogram; clears, accumulates a frame, drains 256 bins
//            over valid/ready and flags pixel-count / border-address errors
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CNT_W     = 14,
  parameter int PIX_TOTAL = 15876
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [LBP_W-1:0]  lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [LBP_W-1:0]  hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_last,
  output logic              busy,
  output logic              done,
  output logic              pix_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] PIX_EXP  = CNT_W'(PIX_TOTAL);
  localparam logic [LBP_W-1:0] LAST_BIN = LBP_W'(NUM_BINS - 1);

  state_e           state_q, state_d;
  logic [LBP_W-1:0] clr_idx_q, clr_idx_d;
  logic [LBP_W-1:0] drain_idx_q, drain_idx_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             pix_err_q, pix_err_d;
  logic             finish_q;
  logic             hist_valid_q, hist_last_q, busy_q, done_q;
  logic             fin_rise, accept, inc_en;

  assign fin_rise = finish && !finish_q;
  assign accept   = hist_valid_q && hist_ready;
  assign inc_en   = (state_q == S_ACCUM) && lbp_valid;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    drain_idx_d = drain_idx_q;
    pix_cnt_d   = pix_cnt_q;
    pix_err_d   = pix_err_q;
    case (state_q)
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + LBP_W'(1);
        if (lbp_valid) begin
          pix_err_d = 1'b1;
        end
        if (clr_idx_q == LAST_BIN) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (lbp_valid) begin
          if (pix_cnt_q != CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
          if (is_border(lbp_addr)) begin
            pix_err_d = 1'b1;
          end
        end
        // Count check uses pix_cnt_d so a code arriving with the finish edge is included.
        if (fin_rise) begin
          state_d     = S_DRAIN;
          drain_idx_d = '0;
          if (pix_cnt_d != PIX_EXP) begin
            pix_err_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (lbp_valid) begin
          pix_err_d = 1'b1;
        end
        if (accept) begin
          drain_idx_d = drain_idx_q + LBP_W'(1);
          if (drain_idx_q == LAST_BIN) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!finish) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
          pix_cnt_d = '0;
          pix_err_d = 1'b0;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      clr_idx_q    <= '0;
      drain_idx_q  <= '0;
      pix_cnt_q    <= '0;
      pix_err_q    <= 1'b0;
      finish_q     <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      drain_idx_q  <= drain_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_err_q    <= pix_err_d;
      finish_q     <= finish;
      hist_valid_q <= (state_d == S_DRAIN);
      hist_last_q  <= (state_d == S_DRAIN) && (drain_idx_d == LAST_BIN);
      // busy stays up for the final clear cycle so upstream starts strictly after it.
      busy_q       <= (state_d == S_CLEAR) || (state_d == S_DRAIN) || (state_q == S_CLEAR);
      done_q       <= (state_d == S_DONE);
    end
  end

  lbp_hist_bank #(
    .CNT_W(CNT_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .clr_en_i  (state_q == S_CLEAR),
    .clr_idx_i (clr_idx_q),
    .inc_en_i  (inc_en),
    .inc_idx_i (lbp_data),
    .rd_en_i   (state_d == S_DRAIN),
    .rd_idx_i  (drain_idx_d),
    .rd_data_o (hist_count)
  );

  assign hist_valid = hist_valid_q;
  assign hist_bin   = drain_idx_q;
  assign hist_last  = hist_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pix_err    = pix_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
// -----------------------------------------------------------------------------
// tb_lbp_hist : directed self-checking bench for lbp_hist
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        hist_ready = 1'b0;
  logic        hist_valid;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_last;
  logic        busy;
  logic        done;
  logic        pix_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_bin [256];
  int bb [256];
  int bc [256];
  int bl [256];
  int nbeats = 0;

  lbp_hist #(.CNT_W(14), .PIX_TOTAL(15876)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last),
    .busy       (busy),
    .done       (done),
    .pix_err    (pix_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) exp_bin[i] = 0;
  endtask

  task automatic wait_accum();
    int c;
    c = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_accum: busy=%b, want 0 within 1000 cycles", busy);
    end
  endtask

  // mode 0: code i%256, mode 1: 8'hFF, mode 2: (7i+3)%256; interior raster addresses
  task automatic feed(input int n, input int mode, input int gap, input bit with_finish);
    int code, row, col;
    logic [6:0] r7, c7;
    for (int i = 0; i < n; i++) begin
      code = (mode == 0) ? (i % 256) : (mode == 1) ? 255 : ((i * 7 + 3) % 256);
      row = 1 + i / 126;
      col = 1 + i % 126;
      r7 = row[6:0];
      c7 = col[6:0];
      lbp_valid = 1'b1;
      lbp_addr  = {r7, c7};
      lbp_data  = code[7:0];
      exp_bin[code]++;
      if (with_finish && i == n - 1) finish = 1'b1;
      @(negedge clk);
      if (gap > 0 && (i % gap) == gap - 1 && i < n - 1) begin
        lbp_valid = 1'b0;
        @(negedge clk);
      end
    end
    lbp_valid = 1'b0;
  endtask

  task automatic drain_all();
    int cyc;
    cyc = 0;
    nbeats = 0;
    while (nbeats < 256 && cyc < 2000) begin
      hist_ready = 1'b1;
      if (hist_valid === 1'b1) begin
        bb[nbeats] = hist_bin;
        bc[nbeats] = hist_count;
        bl[nbeats] = hist_last;
        nbeats++;
      end
      @(negedge clk);
      cyc++;
    end
    hist_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({hist_valid, hist_last, busy, done, pix_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 00000", {hist_valid, hist_last, busy, done, pix_err});
    end
    n_cmp++;
    if ({hist_bin, hist_count} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_data: bin=%0d count=%0d, want 0/0", hist_bin, hist_count);
    end
    reset = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || hist_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clear_busy: %0d of cycles 1..256 wrong, want busy=1 throughout", bad);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_end: busy=%b at cycle 257, want 0", busy);
    end
  endtask

  task automatic test_uniform();
    int bad_bin, bad_cnt, bad_last, want;
    bad_bin = 0; bad_cnt = 0; bad_last = 0;
    clear_model();
    feed(15876, 0, 5, 1'b1);
    n_cmp++;
    if (hist_valid !== 1'b1 || hist_bin !== 8'd0) begin
      n_fail++;
      $display("FAIL uni_first_beat: valid=%b bin=%0d, want 1/0", hist_valid, hist_bin);
    end
    drain_all();
    n_cmp++;
    if (nbeats != 256) begin
      n_fail++;
      $display("FAIL uni_beats: got %0d, want 256", nbeats);
    end
    for (int b = 0; b < nbeats; b++) begin
      want = (b < 4) ? 63 : 62;
      if (bb[b] != b) bad_bin++;
      if (bc[b] != want) bad_cnt++;
      if (bl[b] != ((b == 255) ? 1 : 0)) bad_last++;
    end
    n_cmp++;
    if (bad_bin != 0) begin n_fail++; $display("FAIL uni_order: %0d bad bin indices, want 0", bad_bin); end
    n_cmp++;
    if (bad_cnt != 0) begin n_fail++; $display("FAIL uni_counts: %0d bad counts (bin3=%0d want 63, bin4=%0d want 62)", bad_cnt, bc[3], bc[4]); end
    n_cmp++;
    if (bad_last != 0) begin n_fail++; $display("FAIL uni_last: %0d bad hist_last, want 0", bad_last); end
    n_cmp++;
    if ({done, pix_err, hist_valid, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL uni_done: done/pix_err/valid/busy=%b, want 1000", {done, pix_err, hist_valid, busy});
    end
    finish = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    wait_accum();
    clear_model();
    feed(15876, 1, 0, 1'b0);
    finish = 1'b1;
    @(negedge clk);
    drain_all();
    n_cmp++;
    if (nbeats != 256) begin n_fail++; $display("FAIL b2b_beats: got %0d, want 256", nbeats); end
    n_cmp++;
    if (bc[255] != 15876) begin n_fail++; $display("FAIL b2b_bin255: got %0d, want 15876", bc[255]); end
    for (int b = 0; b < 255; b++) if (bc[b] != 0) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_others: %0d nonzero bins, want 0", bad); end
    n_cmp++;
    if (pix_err !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_status: pix_err=%b done=%b, want 0/1", pix_err, done);
    end
    finish = 1'b0;
  endtask

  task automatic test_stall();
    int cyc, stall, hold_bad, bad;
    bit r;
    cyc = 0; stall = 0; hold_bad = 0; bad = 0;
    wait_accum();
    clear_model();
    feed(300, 2, 0, 1'b1);
    nbeats = 0;
    while (nbeats < 256 && cyc < 3000) begin
      if (hist_valid === 1'b1 && hist_bin == 8'd17 && stall < 10) begin
        r = 1'b0;
        if (hist_count !== 14'd2 || hist_last !== 1'b0) hold_bad++;
        stall++;
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      hist_ready = r;
      if (hist_valid === 1'b1 && r) begin
        bb[nbeats] = hist_bin;
        bc[nbeats] = hist_count;
        nbeats++;
      end
      @(negedge clk);
      cyc++;
    end
    hist_ready = 1'b0;
    n_cmp++;
    if (stall != 10 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: stalled %0d cycles with %0d changes, want 10/0", stall, hold_bad);
    end
    n_cmp++;
    if (nbeats != 256) begin n_fail++; $display("FAIL stall_beats: got %0d, want 256", nbeats); end
    for (int b = 0; b < nbeats; b++) if (bb[b] != b || bc[b] != exp_bin[b]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_seq: %0d bad beats, want 0", bad); end
    n_cmp++;
    if (pix_err !== 1'b1) begin n_fail++; $display("FAIL stall_pixerr: got %b, want 1 (300 pixels)", pix_err); end
    finish = 1'b0;
  endtask

  task automatic test_pix_err();
    wait_accum();
    n_cmp++;
    if (pix_err !== 1'b0) begin n_fail++; $display("FAIL perr_cleared: got %b, want 0", pix_err); end
    clear_model();
    feed(100, 0, 0, 1'b0);
    n_cmp++;
    if (pix_err !== 1'b0) begin n_fail++; $display("FAIL perr_before_finish: got %b, want 0", pix_err); end
    finish = 1'b1;
    @(negedge clk);
    drain_all();
    n_cmp++;
    if (pix_err !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_short_frame: pix_err=%b done=%b, want 1/1", pix_err, done);
    end
    finish = 1'b0;
    wait_accum();
    lbp_valid = 1'b1;
    lbp_addr  = 14'd0;
    lbp_data  = 8'd5;
    @(negedge clk);
    lbp_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pix_err !== 1'b1) begin n_fail++; $display("FAIL perr_border: got %b, want 1", pix_err); end
    finish = 1'b1;
    @(negedge clk);
    drain_all();
    n_cmp++;
    if (nbeats != 256 || bc[5] != 1 || bc[4] != 0) begin
      n_fail++;
      $display("FAIL perr_border_counted: beats=%0d bin5=%0d bin4=%0d, want 256/1/0", nbeats, bc[5], bc[4]);
    end
    finish = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int c, bad;
    c = 0; bad = 0;
    wait_accum();
    clear_model();
    feed(50, 0, 0, 1'b1);
    while (!(hist_valid === 1'b1 && hist_bin == 8'd40) && c < 300) begin
      hist_ready = 1'b1;
      @(negedge clk);
      c++;
    end
    hist_ready = 1'b0;
    n_cmp++;
    if (hist_bin !== 8'd40) begin n_fail++; $display("FAIL mid_reach40: bin=%0d, want 40", hist_bin); end
    reset  = 1'b0;
    finish = 1'b0;
    #1;
    n_cmp++;
    if ({hist_valid, hist_last, busy, done, pix_err} !== 5'b0 || hist_bin !== 8'd0 || hist_count !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ctrl=%b bin=%0d count=%0d, want all 0",
               {hist_valid, hist_last, busy, done, pix_err}, hist_bin, hist_count);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_accum();
    clear_model();
    feed(15876, 2, 0, 1'b1);
    drain_all();
    for (int b = 0; b < nbeats; b++) if (bb[b] != b || bc[b] != exp_bin[b]) bad++;
    n_cmp++;
    if (nbeats != 256 || bad != 0) begin
      n_fail++;
      $display("FAIL mid_next_frame: beats=%0d bad=%0d, want 256/0", nbeats, bad);
    end
    n_cmp++;
    if (pix_err !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_next_status: pix_err=%b done=%b, want 0/1", pix_err, done);
    end
    finish = 1'b0;
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_back_to_back();
    test_stall();
    test_pix_err();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
